// File: rtl/dm_sba_mem_responder.sv
// SBA bus target: single-port word memory on the req/gnt/r_valid protocol.
// Latency: gnt_o GntDelay cycles after first req_i; r_valid_o RespLatency cycles after gnt_o.
// Backpressure: one outstanding transaction; req_i is stalled (no gnt_o) until the response has gone out.
module dm_sba_mem_responder #(
    parameter int unsigned         BusWidth    = 32,
    parameter int unsigned         Depth       = 16,
    parameter logic [BusWidth-1:0] BaseAddr    = 'h1000,
    parameter int unsigned         GntDelay    = 0,
    parameter int unsigned         RespLatency = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [BusWidth-1:0]   add_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   wdata_i,
    input  logic [BusWidth/8-1:0] be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [BusWidth-1:0]   r_rdata_o,
    output logic                  r_err_o,
    output logic                  r_other_err_o
);
    localparam int unsigned         NBytes   = BusWidth / 8;
    localparam int unsigned         OffW     = $clog2(NBytes);
    localparam int unsigned         IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [BusWidth-1:0] DepthW   = BusWidth'(Depth);
    localparam logic [3:0]          GntLoad  = (GntDelay > 0) ? 4'(GntDelay - 1) : 4'd0;
    localparam logic [3:0]          RespLoad = 4'(RespLatency - 1);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, RESP} state_t;

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic                gnt;
    logic                r_valid;
    logic [BusWidth-1:0] offs, idx_full;
    logic [IdxW-1:0]     idx;
    logic                in_range, be_ok, do_write;
    logic                err_q, other_err_q;
    logic [BusWidth-1:0] rdata_q;
    logic [BusWidth-1:0] mem [Depth];

    // Full-width compare on both bounds so addresses below BaseAddr never alias via wrap-around.
    assign offs     = add_i - BaseAddr;
    assign idx_full = offs >> OffW;
    assign idx      = idx_full[IdxW-1:0];
    assign in_range = (add_i >= BaseAddr) && (idx_full < DepthW);
    assign be_ok    = |be_i;
    assign do_write = gnt && we_i && in_range && be_ok;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i) begin
                    if (GntDelay == 0) begin
                        gnt     = 1'b1;
                        state_n = RESP;
                        cnt_n   = RespLoad;
                    end else begin
                        state_n = WAIT_GNT;
                        cnt_n   = GntLoad;
                    end
                end
            end
            WAIT_GNT: begin
                if (!req_i) begin
                    state_n = IDLE;
                end else if (cnt == 4'd0) begin
                    gnt     = 1'b1;
                    state_n = RESP;
                    cnt_n   = RespLoad;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                if (cnt == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (rst_i) begin
            gnt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            err_q       <= 1'b0;
            other_err_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (gnt) begin
                err_q       <= !in_range;
                other_err_q <= in_range && !be_ok;
                rdata_q     <= (!we_i && in_range && be_ok) ? mem[idx] : '0;
            end
        end
    end

    // Memory is intentionally outside reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int unsigned b = 0; b < NBytes; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign r_valid       = (state == RESP) && (cnt == 4'd0) && !rst_i;
    assign gnt_o         = gnt;
    assign r_valid_o     = r_valid;
    assign r_rdata_o     = r_valid ? rdata_q : '0;
    assign r_err_o       = r_valid && err_q;
    assign r_other_err_o = r_valid && other_err_q;

endmodule

// File: tb/tb_dm_sba_mem_responder.sv
// Bench for dm_sba_mem_responder: three instances with different grant/response latencies.
// Latency: checks gnt_o and r_valid_o cycle by cycle against a word-array reference model.
// Backpressure: exercises held req_i (back-to-back), aborted requests and reset mid-response.
module tb_dm_sba_mem_responder;
    logic        clk;
    logic        rst  [3];
    logic        req  [3];
    logic [31:0] add  [3];
    logic        we   [3];
    logic [31:0] wd   [3];
    logic [3:0]  be   [3];
    logic        gnt  [3];
    logic        rv   [3];
    logic [31:0] rd   [3];
    logic        er   [3];
    logic        oe   [3];

    logic [31:0] mdl [3][16];
    int          gd_of [3] = '{0, 2, 0};
    int          rl_of [3] = '{1, 3, 4};
    int          compared   = 0;
    int          mismatched = 0;

    dm_sba_mem_responder #(.GntDelay(0), .RespLatency(1)) u_a (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .add_i(add[0]), .we_i(we[0]),
        .wdata_i(wd[0]), .be_i(be[0]), .gnt_o(gnt[0]), .r_valid_o(rv[0]),
        .r_rdata_o(rd[0]), .r_err_o(er[0]), .r_other_err_o(oe[0]));
    dm_sba_mem_responder #(.GntDelay(2), .RespLatency(3)) u_b (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .add_i(add[1]), .we_i(we[1]),
        .wdata_i(wd[1]), .be_i(be[1]), .gnt_o(gnt[1]), .r_valid_o(rv[1]),
        .r_rdata_o(rd[1]), .r_err_o(er[1]), .r_other_err_o(oe[1]));
    dm_sba_mem_responder #(.GntDelay(0), .RespLatency(4)) u_c (
        .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .add_i(add[2]), .we_i(we[2]),
        .wdata_i(wd[2]), .be_i(be[2]), .gnt_o(gnt[2]), .r_valid_o(rv[2]),
        .r_rdata_o(rd[2]), .r_err_o(er[2]), .r_other_err_o(oe[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input int u, input string tag);
        chk($sformatf("%s u%0d gnt", tag, u), 32'(gnt[u]), 32'd0);
        chk($sformatf("%s u%0d r_valid", tag, u), 32'(rv[u]), 32'd0);
        chk($sformatf("%s u%0d rdata", tag, u), rd[u], 32'd0);
        chk($sformatf("%s u%0d err", tag, u), 32'(er[u]), 32'd0);
        chk($sformatf("%s u%0d other_err", tag, u), 32'(oe[u]), 32'd0);
    endtask

    // Called at (or just after) a falling edge; returns at a falling edge after the response.
    task automatic txn(input int u, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic hold);
        int          gd = gd_of[u];
        int          rl = rl_of[u];
        logic [31:0] wi = (a - 32'h1000) / 4;
        logic        in_r = (a >= 32'h1000) && (wi < 16);
        logic        e_err = !in_r;
        logic        e_oerr = in_r && (b == 4'd0);
        logic [31:0] e_rd = (!w && in_r && b != 4'd0) ? mdl[u][wi[3:0]] : 32'd0;
        req[u] = 1'b1; we[u] = w; add[u] = a; wd[u] = d; be[u] = b;
        for (int k = 0; k <= gd + rl; k++) begin
            #1;
            chk($sformatf("u%0d a=%h gnt k%0d", u, a, k), 32'(gnt[u]), 32'(k == gd));
            chk($sformatf("u%0d a=%h r_valid k%0d", u, a, k), 32'(rv[u]), 32'(k == gd + rl));
            if (k == gd + rl) begin
                chk($sformatf("u%0d a=%h rdata", u, a), rd[u], e_rd);
                chk($sformatf("u%0d a=%h err", u, a), 32'(er[u]), 32'(e_err));
                chk($sformatf("u%0d a=%h other_err", u, a), 32'(oe[u]), 32'(e_oerr));
            end
            @(negedge clk);
            if (k == gd && !hold) req[u] = 1'b0;
        end
        if (w && in_r && b != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) mdl[u][wi[3:0]][8*i +: 8] = d[8*i +: 8];
            end
        end
        if (!hold) begin
            #1;
            chk_quiet(u, "post");
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; req[u] = 1'b0; we[u] = 1'b0;
            add[u] = '0; wd[u] = '0; be[u] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < 3; u++) chk_quiet(u, "reset");
        req[0] = 1'b1;
        #1;
        chk("reset req gnt", 32'(gnt[0]), 32'd0);
        @(negedge clk);
        req[0] = 1'b0;
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) chk_quiet(u, "idle");

        // Fill every word so later reads have defined expectations.
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 16; i++) begin
                txn(u, 1'b1, 32'h1000 + 32'(4 * i), $urandom, 4'hF, 1'b0);
            end
        end

        txn(0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 1'b0);
        txn(0, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0);
        chk("full word read", mdl[0][1], 32'hDEADBEEF);
        txn(0, 1'b1, 32'h1004, 32'h0000AB00, 4'h2, 1'b0);
        txn(0, 1'b0, 32'h1004, 32'h0, 4'h1, 1'b0);
        chk("byte masked write", mdl[0][1], 32'hDEADABEF);
        txn(0, 1'b0, 32'h0FFC, 32'h0, 4'hF, 1'b0);
        txn(0, 1'b0, 32'h1040, 32'h0, 4'hF, 1'b0);
        txn(0, 1'b1, 32'h1040, 32'h12345678, 4'hF, 1'b0);
        txn(0, 1'b1, 32'h0FFC, 32'h12345678, 4'hF, 1'b0);
        txn(0, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0);
        txn(0, 1'b0, 32'h103C, 32'h0, 4'hF, 1'b0);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
        txn(0, 1'b1, 32'h1008, 32'hCAFEF00D, 4'h0, 1'b0);
        txn(0, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0);
        txn(0, 1'b0, 32'h1007, 32'h0, 4'hF, 1'b1);
        txn(0, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b1);
        txn(0, 1'b1, 32'h100C, 32'h0BADCAFE, 4'hF, 1'b0);
        txn(0, 1'b0, 32'h100D, 32'h0, 4'h8, 1'b0);

        txn(1, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0);
        txn(1, 1'b1, 32'h1010, 32'h55AA33CC, 4'hC, 1'b1);
        txn(1, 1'b0, 32'h1010, 32'h0, 4'hF, 1'b0);

        // Request withdrawn before its delayed grant: nothing may come back.
        req[1] = 1'b1; we[1] = 1'b1; add[1] = 32'h1000; wd[1] = 32'hFFFFFFFF; be[1] = 4'hF;
        #1;
        chk("abort gnt c0", 32'(gnt[1]), 32'd0);
        @(negedge clk);
        req[1] = 1'b0;
        for (int k = 1; k < 8; k++) begin
            #1;
            chk_quiet(1, $sformatf("abort c%0d", k));
            @(negedge clk);
        end
        txn(1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);

        // Reset during the response window: granted write sticks, response is dropped.
        req[2] = 1'b1; we[2] = 1'b1; add[2] = 32'h1008; wd[2] = 32'hA5A5_1234; be[2] = 4'hF;
        #1;
        chk("rstmid gnt", 32'(gnt[2]), 32'd1);
        @(negedge clk);
        req[2] = 1'b0;
        #1;
        chk("rstmid r_valid c1", 32'(rv[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        chk_quiet(2, "rstmid during");
        @(negedge clk);
        rst[2] = 1'b0;
        mdl[2][2] = 32'hA5A5_1234;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk_quiet(2, $sformatf("rstmid after c%0d", k));
            @(negedge clk);
        end
        txn(2, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0);
        txn(2, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0);

        for (int u = 0; u < 3; u++) begin
            for (int n = 0; n < 25; n++) begin
                txn(u, 1'($urandom_range(0, 1)), 32'h0FF0 + 32'($urandom_range(0, 'h60)),
                    $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            req[u] = 1'b0;
            @(negedge clk);
            #1;
            chk_quiet(u, "rand end");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
